// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op-codes and FSM states for the sequential ALU
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/add_nbit.sv
// rtl/add_nbit.sv - WIDTH-bit ripple-carry adder with carry in/out
module add_nbit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - registered N-bit ALU with single-cycle ops and shift-add multiply
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Cntrl,
    output logic [WIDTH-1:0] Out,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;

    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum;
    logic             add_cout;
    logic             add_ovf;
    logic [WIDTH-1:0] res_out;
    logic             res_cout;
    logic             res_ovf;

    // SUB and SLT share the adder as A + ~B + 1
    assign is_sub = (Cntrl == ALU_SUB) || (Cntrl == ALU_SLT);
    assign b_op   = is_sub ? ~B : B;

    add_nbit #(.WIDTH(WIDTH)) u_add (
        .a    (A),
        .b    (b_op),
        .cin  (is_sub),
        .sum  (sum),
        .cout (add_cout)
    );

    assign add_ovf  = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign acc_next = mplier[0] ? acc + mcand : acc;

    always_comb begin
        res_out  = '0;
        res_cout = 1'b0;
        res_ovf  = 1'b0;
        case (Cntrl)
            ALU_ADD, ALU_SUB: begin
                res_out  = sum;
                res_cout = add_cout;
                res_ovf  = add_ovf;
            end
            ALU_XOR: res_out = A ^ B;
            ALU_SLT: res_out = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            default: res_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            Out      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        if (Cntrl == ALU_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, A};
                            mplier <= B;
                            acc    <= '0;
                            cnt    <= CW'(WIDTH);
                            Busy   <= 1'b1;
                            state  <= ST_MUL;
                        end else begin
                            Out      <= res_out;
                            Cout     <= res_cout;
                            Overflow <= res_ovf;
                            Zero     <= (res_out == '0);
                            Done     <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt != '0) begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - CW'(1);
                    end else begin
                        // one extra cycle after the last iteration to publish the product
                        Out      <= acc[WIDTH-1:0];
                        Cout     <= 1'b0;
                        Overflow <= |acc[2*WIDTH-1:WIDTH];
                        Zero     <= (acc[WIDTH-1:0] == '0);
                        Done     <= 1'b1;
                        Busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb/tb_alu_nbit_seq.sv - scoreboard bench for alu_nbit_seq at WIDTH=8
module tb_alu_nbit_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   Cntrl;
    logic [W-1:0] Out;
    logic         Cout;
    logic         Overflow;
    logic         Zero;
    logic         Busy;
    logic         Done;

    typedef struct packed {
        logic [W-1:0] out;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   run     = 0;
    int   max_run = 0;

    alu_nbit_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .Cntrl    (Cntrl),
        .Out      (Out),
        .Cout     (Cout),
        .Overflow (Overflow),
        .Zero     (Zero),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] o, input logic c, input logic v, input logic z);
        exp_t e;
        e.out  = o;
        e.cout = c;
        e.ovf  = v;
        e.zero = z;
        return e;
    endfunction

    // monitor: every Done must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (Done) begin
            run++;
            if (run > max_run) max_run = run;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got Out=%0h expected no Done", Out);
            end else begin
                e = q.pop_front();
                chk("out",  Out,      e.out);
                chk("cout", Cout,     e.cout);
                chk("ovf",  Overflow, e.ovf);
                chk("zero", Zero,     e.zero);
            end
        end else begin
            run = 0;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input exp_t e);
        Start = 1'b1;
        Cntrl = op;
        A     = a;
        B     = b;
        if (push) q.push_back(e);
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic mul_run(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e,
                           input logic inject);
        int busy_n;
        busy_n = 0;
        issue(3'b100, a, b, 1'b1, e);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!Busy) break;
            busy_n++;
            if (inject && busy_n == 3) begin
                Start = 1'b1;
                Cntrl = 3'b000;
                A     = 8'h11;
                B     = 8'h22;
            end
            if (busy_n == 4) Start = 1'b0;
        end
        Start = 1'b0;
        chk("mul_busy_cycles", busy_n, 9);
        chk("mul_done_at_busy_fall", Done, 1'b1);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        chk("mul_queue_drained", q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dones;
        reset = 1'b1;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        Cntrl = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out",  Out,      8'h00);
        chk("rst_cout", Cout,     1'b0);
        chk("rst_ovf",  Overflow, 1'b0);
        chk("rst_zero", Zero,     1'b1);
        chk("rst_busy", Busy,     1'b0);
        chk("rst_done", Done,     1'b0);
        @(posedge clk);
        #1;

        issue(3'b000, 8'hFF, 8'h01, 1'b1, mk(8'h00, 1'b1, 1'b0, 1'b1));
        issue(3'b000, 8'h7F, 8'h01, 1'b1, mk(8'h80, 1'b0, 1'b1, 1'b0));
        @(posedge clk);
        #1;

        max_run = 0;
        issue(3'b001, 8'h80, 8'h01, 1'b1, mk(8'h7F, 1'b1, 1'b1, 1'b0));
        issue(3'b010, 8'hA5, 8'h5A, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        chk("back_to_back_done_run", max_run, 2);

        issue(3'b011, 8'hFE, 8'h01, 1'b1, mk(8'h01, 1'b0, 1'b0, 1'b0));
        issue(3'b011, 8'h01, 8'hFE, 1'b1, mk(8'h00, 1'b0, 1'b0, 1'b1));
        issue(3'b011, 8'h80, 8'h7F, 1'b1, mk(8'h01, 1'b0, 1'b0, 1'b0));
        issue(3'b101, 8'h12, 8'h34, 1'b1, mk(8'h00, 1'b0, 1'b0, 1'b1));
        repeat (2) @(posedge clk);
        #1;

        max_run = 0;
        mul_run(8'h0D, 8'h0B, mk(8'h8F, 1'b0, 1'b0, 1'b0), 1'b1);
        chk("mul_single_done", max_run, 1);
        mul_run(8'h10, 8'h10, mk(8'h00, 1'b0, 1'b1, 1'b1), 1'b0);

        // abort a multiply with reset mid-flight
        issue(3'b100, 8'hFF, 8'hFF, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy_before_reset", Busy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_out",  Out,  8'h00);
        chk("abort_zero", Zero, 1'b1);
        chk("abort_busy", Busy, 1'b0);
        dones = 0;
        @(posedge clk);
        #1;
        issue(3'b000, 8'h02, 8'h03, 1'b1, mk(8'h05, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (Done) dones++;
        end
        chk("abort_only_add_done", dones, 1);
        #1;
        chk("final_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
